// File: rtl/cpa_pkg.sv
// Shared helpers for the pipelined carry-propagate adder: segment geometry
// and the encoding of the add/subtract mode input.
package cpa_pkg;

    // Mode input encoding
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Integer ceiling division, used to size the ripple segments
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Lowest bit index covered by segment i
    function automatic int seg_lo(input int i, input int seg);
        return i * seg;
    endfunction

    // Highest bit index covered by segment i; trailing segments are clipped
    // to the operand width and may be narrower than seg
    function automatic int seg_hi(input int i, input int seg, input int width);
        int top;
        top = (i + 1) * seg;
        if (top > width) begin
            top = width;
        end
        return top - 1;
    endfunction

endpackage

// File: rtl/cpa_segment.sv
// One ripple segment of the carry-propagate adder. Purely combinational:
// per-bit generate/propagate followed by a serial carry chain. Besides the
// carry out it exposes the carry into its top bit so the segment that holds
// the operand MSB can form the signed-overflow flag.
module cpa_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cmsb
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   carry;

    assign p = a ^ b;
    assign g = a & b;

    // Ripple the carry: carry into bit i+1 is g_i | p_i & carry into bit i
    always_comb begin
        carry[0] = ci;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = g[i] | (p[i] & carry[i]);
        end
    end

    assign s    = p ^ carry[W-1:0];
    assign co   = carry[W];
    assign cmsb = carry[W-1];

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined ripple carry-propagate adder/subtractor with elastic valid/ready
// handshakes. The WIDTH-bit add is cut into STAGES ripple segments; each
// stage adds its own segment using the carry registered by the stage below
// and forwards the finished low sum bits together with the still-unused
// upper operand bits (skewed operands). The last stage register drives the
// outputs directly.
module pipelined_cpa
    import cpa_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = ceil_div(WIDTH, STAGES);

    // Handshake state: one valid bit per stage
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    // space[k]: stage k may take a new item this cycle; space[STAGES] is the consumer
    logic [STAGES:0]   space;

    // Stage registers
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             c_p   [STAGES];
    logic             ovf_p [STAGES];

    // Values each stage would capture on a load
    logic [WIDTH-1:0] a_n   [STAGES];
    logic [WIDTH-1:0] b_n   [STAGES];
    logic [WIDTH-1:0] sum_n [STAGES];
    logic             c_n   [STAGES];
    logic             ovf_n [STAGES];

    // Subtraction is a + ~b + 1; the external carry-in is ignored then
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c0    = (sub == MODE_SUB) ? 1'b1 : cin;

    // Elastic advance chain, evaluated from the output side down to stage 0
    always_comb begin
        space         = '0;
        adv           = '0;
        load          = '0;
        space[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]   = vld[k] && space[k+1];
            space[k] = !vld[k] || adv[k];
        end
        load[0] = in_valid && space[0];
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    assign in_ready = space[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, SEG);
        localparam int HI = seg_hi(k, SEG, WIDTH);

        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic             src_o;

        if (k == 0) begin : g_src_in
            assign src_a = a;
            assign src_b = b_eff;
            assign src_s = '0;
            assign src_c = c0;
            assign src_o = 1'b0;
        end else begin : g_src_reg
            assign src_a = a_p[k-1];
            assign src_b = b_p[k-1];
            assign src_s = sum_p[k-1];
            assign src_c = c_p[k-1];
            assign src_o = ovf_p[k-1];
        end

        // Upper operand bits travel unchanged to the next stage
        assign a_n[k] = src_a;
        assign b_n[k] = src_b;

        if (LO < WIDTH) begin : g_seg
            logic [HI-LO:0]   seg_s;
            logic             seg_co;
            logic             seg_cm;
            logic [WIDTH-1:0] merged;

            cpa_segment #(
                .W (HI - LO + 1)
            ) u_seg (
                .a    (src_a[HI:LO]),
                .b    (src_b[HI:LO]),
                .ci   (src_c),
                .s    (seg_s),
                .co   (seg_co),
                .cmsb (seg_cm)
            );

            // Drop this segment's sum bits into the forwarded partial sum
            always_comb begin
                merged        = src_s;
                merged[HI:LO] = seg_s;
            end

            assign sum_n[k] = merged;
            assign c_n[k]   = seg_co;
            // Only the segment holding the MSB knows the carry into bit WIDTH-1
            assign ovf_n[k] = (HI == WIDTH - 1) ? (seg_cm ^ seg_co) : src_o;
        end else begin : g_pass
            // Empty segment when STAGES*SEG overshoots WIDTH: just a delay slot
            assign sum_n[k] = src_s;
            assign c_n[k]   = src_c;
            assign ovf_n[k] = src_o;
        end
    end

    // Valid bits: set on load, cleared when the item moves on and nothing replaces it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld[k] <= 1'b0;
                end
            end
        end
    end

    // Stage data: captured only on a load, held while the stage is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                sum_p[k] <= '0;
                c_p[k]   <= 1'b0;
                ovf_p[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    a_p[k]   <= a_n[k];
                    b_p[k]   <= b_n[k];
                    sum_p[k] <= sum_n[k];
                    c_p[k]   <= c_n[k];
                    ovf_p[k] <= ovf_n[k];
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = sum_p[STAGES-1];
    assign cout      = c_p[STAGES-1];
    assign ovf       = ovf_p[STAGES-1];

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa: directed cases on 8/2 and 32/4 instances
// (overflow, subtraction, full carry chain, backpressure, mid-stream reset)
// plus a randomized sweep over several WIDTH/STAGES pairs scored against an
// arithmetic reference model.
module tb_pipelined_cpa;

    localparam int NCFG   = 10;
    localparam int SW_CYC = 300;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mark_done();
        n_done++;
    endtask

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 1;
            1, 2, 3: return 7;
            4, 5, 6: return 16;
            default: return 33;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 1;
            2: return 3;
            3: return 7;
            4: return 1;
            5: return 3;
            6: return 16;
            7: return 1;
            8: return 3;
            default: return 33;
        endcase
    endfunction

    function automatic longint sext(input longint unsigned v, input int w);
        if (v[w-1]) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Reference: {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [65:0] cpa_model(input int w, input longint unsigned av,
                                              input longint unsigned bv, input logic c, input logic s);
        longint unsigned m;
        longint unsigned full;
        longint          sr;
        longint          lo;
        longint          hi;
        logic [65:0]     r;
        m  = (64'd1 << w) - 64'd1;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        if (!s) begin
            full = av + bv + longint'(c);
            sr   = sext(av, w) + sext(bv, w) + longint'(c);
        end else begin
            full = av + (m - bv) + 64'd1;
            sr   = sext(av, w) - sext(bv, w);
        end
        r        = '0;
        r[63:0]  = full & m;
        r[64]    = full[w];
        r[65]    = (sr < lo) || (sr > hi);
        return r;
    endfunction

    // ---------------- directed instances ----------------
    logic        rst8, iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, sum8;
    logic        rst32, iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, sum32;

    pipelined_cpa #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(co8), .ovf(of8));

    pipelined_cpa #(.WIDTH(32), .STAGES(4)) u32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(co32), .ovf(of32));

    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        a8 = ta; b8 = tbv; cin8 = tc; sub8 = ts; iv8 = 1'b1; or8 = 1'b1;
        #1 check({tag, "_accept"}, ir8, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            iv8 = 1'b0;
            #1;
            if (c == 2) begin
                check({tag, "_valid"}, ov8, 1);
                check({tag, "_sum"}, sum8, es);
                check({tag, "_cout"}, co8, ec);
                check({tag, "_ovf"}, of8, eo);
            end else begin
                check({tag, "_novalid"}, ov8, 0);
            end
        end
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tbv, input logic tc, input logic ts,
                         input logic [31:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        a32 = ta; b32 = tbv; cin32 = tc; sub32 = ts; iv32 = 1'b1; or32 = 1'b1;
        #1 check({tag, "_accept"}, ir32, 1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            iv32 = 1'b0;
            #1;
            if (c == 4) begin
                check({tag, "_valid"}, ov32, 1);
                check({tag, "_sum"}, sum32, es);
                check({tag, "_cout"}, co32, ec);
                check({tag, "_ovf"}, of32, eo);
            end else begin
                check({tag, "_novalid"}, ov32, 0);
            end
        end
    endtask

    initial begin
        logic [33:0] q[$];
        logic [33:0] held_v;
        logic [65:0] r;
        logic        held, need_new, saw_full;
        int          sent;

        rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        rst32 = 1'b1; iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst32 = 1'b0;
        #1;
        check("rst_in_ready", ir8, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", co8, 0);
        check("rst_ovf", of8, 0);
        check("rst32_in_ready", ir32, 1);
        check("rst32_out_valid", ov32, 0);

        run8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");
        run8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_neg");
        run8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_cin_ignored");
        run8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
        run32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "carry_chain");

        // Backpressure: 10 operands, consumer stalls for 6 cycles mid-stream
        sent = 0; held = 1'b0; held_v = '0; need_new = 1'b1; saw_full = 1'b0;
        for (int n = 0; n < 80 && !(sent == 10 && q.size() == 0); n++) begin
            @(negedge clk);
            or32 = !(n >= 4 && n < 10);
            if (sent < 10) begin
                iv32 = 1'b1;
                if (need_new) begin
                    a32 = $urandom(); b32 = $urandom(); cin32 = 1'($urandom_range(1));
                    sub32 = 1'b0; need_new = 1'b0;
                end
            end else begin
                iv32 = 1'b0;
            end
            #1;
            if (held) begin
                check("bp_hold_valid", ov32, 1);
                check("bp_hold_data", {of32, co32, sum32}, held_v);
            end
            check("bp_in_ready", ir32, !(q.size() == 4 && !or32));
            if (q.size() == 4 && !or32) saw_full = 1'b1;
            if (ov32 && or32) begin
                check("bp_out_has_item", q.size() != 0, 1);
                if (q.size() != 0) check("bp_result", {of32, co32, sum32}, q.pop_front());
            end
            held   = ov32 && !or32;
            held_v = {of32, co32, sum32};
            if (iv32 && ir32) begin
                r = cpa_model(32, 64'(a32), 64'(b32), cin32, sub32);
                q.push_back({r[65], r[64], r[31:0]});
                sent++;
                need_new = 1'b1;
            end
        end
        check("bp_sent", sent, 10);
        check("bp_drained", q.size(), 0);
        check("bp_saw_full", saw_full, 1);

        // Reset with three operands in flight, one already presented and stalled
        @(negedge clk);
        or32 = 1'b1; iv32 = 1'b1; cin32 = 1'b0; sub32 = 1'b0;
        a32 = 32'h1234_5678; b32 = 32'h1111_1111;
        @(negedge clk);
        a32 = 32'h0F0F_0F0F; b32 = 32'h0101_0101;
        @(negedge clk);
        a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0001;
        @(negedge clk);
        iv32 = 1'b0; or32 = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_pre_valid", ov32, 1);
        check("rstmid_pre_sum", sum32, 32'h2345_6789);
        #1 rst32 = 1'b1;
        #1;
        check("rstmid_valid", ov32, 0);
        check("rstmid_sum", sum32, 0);
        check("rstmid_cout", co32, 0);
        check("rstmid_ovf", of32, 0);
        @(negedge clk);
        rst32 = 1'b0; or32 = 1'b1;
        #1 check("rstmid_in_ready", ir32, 1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            #1 check("rstmid_no_stale", ov32, 0);
        end

        for (int t = 0; t < 20000 && n_done < NCFG; t++) @(negedge clk);
        check("sweep_done", n_done, NCFG);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ---------------- randomized sweep instances ----------------
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
        localparam int W = cfg_w(gi);
        localparam int S = cfg_s(gi);

        logic         rst_s, iv, ir, ci, sb, ov, orr, co, of;
        logic [W-1:0] xa, xb, sm;
        logic [W+1:0] q_res [$];
        int           q_cyc [$];
        int           q_stl [$];

        pipelined_cpa #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir), .a(xa), .b(xb),
            .cin(ci), .sub(sb), .out_valid(ov), .out_ready(orr), .sum(sm),
            .cout(co), .ovf(of));

        initial begin
            int           cyc, stalls, c0, s0;
            logic         held;
            logic [W+1:0] held_v;
            logic [65:0]  r;
            int           sel;

            rst_s = 1'b1; iv = 1'b0; orr = 1'b1; ci = 1'b0; sb = 1'b0; xa = '0; xb = '0;
            cyc = 0; stalls = 0; held = 1'b0; held_v = '0;
            repeat (2) @(negedge clk);
            rst_s = 1'b0;
            for (int n = 0; n < SW_CYC + 4 * S + 200; n++) begin
                @(negedge clk);
                if (n < SW_CYC) begin
                    iv  = ($urandom_range(9) < 7);
                    orr = ($urandom_range(9) < 7);
                end else begin
                    iv  = 1'b0;
                    orr = 1'b1;
                end
                sel = $urandom_range(7);
                xa  = (sel == 0) ? '1 : (sel == 1) ? '0 : W'({$urandom(), $urandom()});
                sel = $urandom_range(7);
                xb  = (sel == 0) ? '1 : (sel == 1) ? '0 : W'({$urandom(), $urandom()});
                ci  = 1'($urandom_range(1));
                sb  = 1'($urandom_range(1));
                #1;
                if (held) begin
                    check("sw_hold_valid", ov, 1);
                    check("sw_hold_data", {of, co, sm}, held_v);
                end
                check("sw_in_ready", ir, !(q_res.size() == S && !orr));
                if (ov && orr) begin
                    check("sw_out_has_item", q_res.size() != 0, 1);
                    if (q_res.size() != 0) begin
                        c0 = q_cyc.pop_front();
                        s0 = q_stl.pop_front();
                        check("sw_result", {of, co, sm}, q_res.pop_front());
                        if (s0 == stalls) check("sw_latency", cyc - c0, S);
                    end
                end
                held   = ov && !orr;
                held_v = {of, co, sm};
                if (ov && !orr) stalls++;
                if (iv && ir) begin
                    r = cpa_model(W, 64'(xa), 64'(xb), ci, sb);
                    q_res.push_back({r[65], r[64], r[W-1:0]});
                    q_cyc.push_back(cyc);
                    q_stl.push_back(stalls);
                end
                cyc++;
                if (n >= SW_CYC && q_res.size() == 0) break;
            end
            check("sw_drained", q_res.size(), 0);
            mark_done();
        end
    end

endmodule
